// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - request/status bundle for the serial pattern transmitter
interface seq_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] reps;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, pattern, len, reps,
        input  out, out_valid, busy, done, err
    );

    modport slave (
        input  start, pattern, len, reps,
        output out, out_valid, busy, done, err
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - bit-serial MSB-first pattern transmitter with repeat count
module seq_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    seq_pattern_tx_if.slave   io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    localparam logic [LEN_W-1:0] LP_WIDTH = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LP_ONE_L = LEN_W'(1);
    localparam logic [REP_W-1:0] LP_ONE_R = REP_W'(1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pat, w_pat_src, w_shifted;
    logic [LEN_W-1:0] r_len, r_idx, w_idx_nxt;
    logic [REP_W-1:0] r_rep, w_rep_nxt;
    logic             r_out, r_err;
    logic             w_out_nxt, w_err_nxt, w_load, w_len_ok;

    assign w_len_ok = (io_bus.len != '0) && (io_bus.len <= LP_WIDTH);

    // r_idx always names the bit currently on the line, so the first bit is
    // loaded into r_out on the accepting edge itself.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep;
        w_load      = 1'b0;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            S_SEND: begin
                if (r_idx != '0) begin
                    w_idx_nxt = r_idx - LP_ONE_L;
                end else if (r_rep != '0) begin
                    w_rep_nxt = r_rep - LP_ONE_R;
                    w_idx_nxt = r_len - LP_ONE_L;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                if (io_bus.start) begin
                    if (w_len_ok) begin
                        w_state_nxt = S_SEND;
                        w_load      = 1'b1;
                        w_idx_nxt   = io_bus.len - LP_ONE_L;
                        w_rep_nxt   = io_bus.reps;
                    end else begin
                        w_err_nxt   = 1'b1;
                    end
                end
            end
        endcase
        w_pat_src = w_load ? io_bus.pattern : r_pat;
        w_shifted = w_pat_src >> w_idx_nxt;
        w_out_nxt = (w_state_nxt == S_SEND) & w_shifted[0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_rep   <= '0;
            r_pat   <= '0;
            r_len   <= '0;
            r_out   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_rep   <= w_rep_nxt;
            r_out   <= w_out_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_pat <= io_bus.pattern;
                r_len <= io_bus.len;
            end
        end
    end

    assign io_bus.out       = r_out;
    assign io_bus.out_valid = (r_state == S_SEND);
    assign io_bus.busy      = (r_state == S_SEND);
    assign io_bus.done      = (r_state == S_DONE);
    assign io_bus.err       = r_err;
endmodule
